// File: rtl/matrix_row_scanner.sv
// matrix_row_scanner
// Scans a ROWS x COLS framebuffer out to a serial-in shift-register column
// driver, one row at a time, driving the row select in step.
//
// Per row: SHIFT (2*COLS cycles, MSB first, sdata set with sclk low then
// held while sclk is high), LATCH (1 cycle, row_addr updates), then
// DISPLAY (oe_n low for max(dwell,1) cycles). Rows follow back to back.
// enable is only acted on at row boundaries. Disabling mid-row lets the row
// finish and then parks in IDLE. Re-enabling always restarts at row 0.
//
// Ports:
//   clock, reset         rising-edge clock, synchronous active-high reset
//   enable               scan enable
//   dwell                display cycles per row (0 behaves as 1)
//   fb_wr_en/row/data    framebuffer row write, accepted in every state
//   row_addr             row currently selected on the matrix
//   sclk, sdata, latch   column shift clock, serial data, latch pulse
//   oe_n                 column output enable, active-low
//   frame_done           1-cycle pulse after the last row's display period
//   busy                 high whenever the scanner is not idle
//
// Every output is a flop. The next-state logic computes the output values
// for the state being entered, so each output lines up with its state.
module matrix_row_scanner #(
  parameter int ROWS    = 8,
  parameter int COLS    = 8,
  parameter int DWELL_W = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [DWELL_W-1:0]      dwell,
  input  logic                    fb_wr_en,
  input  logic [$clog2(ROWS)-1:0] fb_wr_row,
  input  logic [COLS-1:0]         fb_wr_data,
  output logic [$clog2(ROWS)-1:0] row_addr,
  output logic                    sclk,
  output logic                    sdata,
  output logic                    latch,
  output logic                    oe_n,
  output logic                    frame_done,
  output logic                    busy
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(2 * COLS);
  localparam logic [CW-1:0] CNT_LAST = CW'(2 * COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DISPLAY} state_t;

  state_t             state, state_n;
  logic [COLS-1:0]    fb [ROWS];
  logic [COLS-1:0]    sr, sr_n;
  logic [CW-1:0]      cnt, cnt_n;
  logic [DWELL_W-1:0] dwell_cnt, dwell_cnt_n;
  logic [RW-1:0]      scan_row, scan_row_n;
  logic [RW-1:0]      load_row;
  logic               load;
  logic [RW-1:0]      row_addr_n;
  logic               sclk_n, sdata_n, latch_n, oe_n_n, frame_done_n;

  always_comb begin
    state_n      = state;
    sr_n         = sr;
    cnt_n        = cnt;
    dwell_cnt_n  = dwell_cnt;
    scan_row_n   = scan_row;
    row_addr_n   = row_addr;
    sdata_n      = sdata;
    sclk_n       = 1'b0;
    latch_n      = 1'b0;
    oe_n_n       = 1'b1;
    frame_done_n = 1'b0;
    load         = 1'b0;
    load_row     = scan_row;

    case (state)
      IDLE: begin
        if (enable) begin
          load       = 1'b1;
          load_row   = '0;
          scan_row_n = '0;
        end
      end
      SHIFT: begin
        // cnt[0]==0 is phase A (data set up), cnt[0]==1 is phase B (sclk high).
        cnt_n = cnt + CW'(1);
        if (!cnt[0]) begin
          sclk_n = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_n    = LATCH;
          latch_n    = 1'b1;
          row_addr_n = scan_row;
          cnt_n      = '0;
        end else begin
          sr_n    = {sr[COLS-2:0], 1'b0};
          sdata_n = sr[COLS-2];
        end
      end
      LATCH: begin
        state_n     = DISPLAY;
        oe_n_n      = 1'b0;
        dwell_cnt_n = (dwell == '0) ? DWELL_W'(1) : dwell;
      end
      DISPLAY: begin
        if (dwell_cnt == DWELL_W'(1)) begin
          scan_row_n   = scan_row + RW'(1);
          frame_done_n = (scan_row == ROW_LAST);
          if (enable) begin
            load     = 1'b1;
            load_row = scan_row + RW'(1);
          end else begin
            state_n = IDLE;
          end
        end else begin
          dwell_cnt_n = dwell_cnt - DWELL_W'(1);
          oe_n_n      = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase

    // Row capture happens on the edge that starts the row's first SHIFT
    // cycle. The array read sees the pre-write contents, so a write landing
    // on that same edge shows up on the next frame.
    if (load) begin
      state_n = SHIFT;
      cnt_n   = '0;
      sr_n    = fb[load_row];
      sdata_n = fb[load_row][COLS-1];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      sr         <= '0;
      cnt        <= '0;
      dwell_cnt  <= '0;
      scan_row   <= '0;
      row_addr   <= '0;
      sclk       <= 1'b0;
      sdata      <= 1'b0;
      latch      <= 1'b0;
      oe_n       <= 1'b1;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      for (int i = 0; i < ROWS; i++) fb[i] <= '0;
    end else begin
      state      <= state_n;
      sr         <= sr_n;
      cnt        <= cnt_n;
      dwell_cnt  <= dwell_cnt_n;
      scan_row   <= scan_row_n;
      row_addr   <= row_addr_n;
      sclk       <= sclk_n;
      sdata      <= sdata_n;
      latch      <= latch_n;
      oe_n       <= oe_n_n;
      frame_done <= frame_done_n;
      busy       <= (state_n != IDLE);
      if (fb_wr_en) fb[fb_wr_row] <= fb_wr_data;
    end
  end

endmodule
